lsu_port_arbiter: RTL

//  Memory-stage load/store controller, next generation of the single-UART MEM stage.

---
 rtl/lsu_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_port_arbiter.sv
// Memory-stage load/store controller: routes one access per instruction to the
// D-cache or to one of NUM_PERIPH stb/ack slaves, builds byte enables, extends
// load data and reports misaligned, unmapped and timed-out accesses.
module lsu_port_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_PERIPH  = 4,
  parameter logic [31:0] PERIPH_BASE = 32'h2000_0000,
  parameter int unsigned PERIPH_SPAN = 12,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  input  logic                       req_rw_i,
  input  logic [1:0]                 req_size_i,
  input  logic                       req_sign_i,
  input  logic [XLEN-1:0]            req_addr_i,
  input  logic [XLEN-1:0]            req_wdata_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic                       done_o,
  output logic [XLEN-1:0]            rdata_o,
  output logic                       fault_o,
  output logic [1:0]                 fault_cause_o,
  output logic                       dc_req_valid_o,
  input  logic                       dc_req_ready_i,
  output logic [XLEN-1:0]            dc_req_addr_o,
  output logic                       dc_req_rw_o,
  output logic [3:0]                 dc_req_be_o,
  output logic [XLEN-1:0]            dc_req_wdata_o,
  input  logic                       dc_rsp_valid_i,
  input  logic [XLEN-1:0]            dc_rsp_data_i,
  output logic [NUM_PERIPH-1:0]      pr_stb_o,
  output logic [PERIPH_SPAN-1:0]     pr_addr_o,
  output logic                       pr_we_o,
  output logic [3:0]                 pr_be_o,
  output logic [XLEN-1:0]            pr_wdata_o,
  input  logic [NUM_PERIPH-1:0]      pr_ack_i,
  input  logic [NUM_PERIPH*XLEN-1:0] pr_rdata_i
);

  localparam int unsigned CNT_W     = 16;
  localparam logic [32:0] WIN_BYTES = 33'(NUM_PERIPH) << PERIPH_SPAN;

  typedef enum logic [2:0] {
    S_IDLE, S_CREQ, S_CWAIT, S_PWAIT, S_DRAIN, S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic                  rw_q, rw_d;
  logic [NUM_PERIPH-1:0] sel_q, sel_d;
  logic [3:0]            be_q, be_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic [1:0]            cause_q, cause_d;

  logic [32:0]           off_c;
  logic                  is_cache_c, is_periph_c, fault_c;
  logic [1:0]            fcause_c;
  logic [NUM_PERIPH-1:0] sel_c;
  logic [3:0]            be_c;
  logic [XLEN-1:0]       wdata_c;
  logic                  ack_hit_c, timeout_c;
  logic [XLEN-1:0]       prdata_c;

  // Select a byte/half lane and zero- or sign-extend it
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] size, input logic sign);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {lane, 3'b000};
    case (size)
      2'b01:   r = {{24{sign & sh[7]}}, sh[7:0]};
      2'b10:   r = {{16{sign & sh[15]}}, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Decode the incoming request: target, fault cause, byte enables, lane data
  always_comb begin
    off_c       = {1'b0, req_addr_i} - {1'b0, PERIPH_BASE};
    is_cache_c  = req_addr_i < PERIPH_BASE;
    is_periph_c = !is_cache_c && (off_c < WIN_BYTES);
    fault_c     = 1'b1;
    fcause_c    = 2'b11;
    if (req_size_i == 2'b00) begin
      fcause_c = 2'b11;
    end else if ((req_size_i == 2'b10 && req_addr_i[0]) ||
                 (req_size_i == 2'b11 && req_addr_i[1:0] != 2'b00)) begin
      fcause_c = 2'b01;
    end else if (is_cache_c || is_periph_c) begin
      fault_c  = 1'b0;
      fcause_c = 2'b00;
    end
    sel_c = '0;
    for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
      if (is_periph_c && ((off_c >> PERIPH_SPAN) == 33'(k))) sel_c[k] = 1'b1;
    end
    case (req_size_i)
      2'b01:   be_c = 4'b0001 << req_addr_i[1:0];
      2'b10:   be_c = 4'b0011 << {req_addr_i[1], 1'b0};
      2'b11:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
    case (req_size_i)
      2'b01:   wdata_c = {4{req_wdata_i[7:0]}};
      2'b10:   wdata_c = {2{req_wdata_i[15:0]}};
      default: wdata_c = req_wdata_i;
    endcase
  end

  // Selected-slave acknowledge, read data and the ack timeout
  always_comb begin
    ack_hit_c = |(pr_ack_i & sel_q);
    timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC));
    prdata_c  = '0;
    for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
      if (sel_q[k]) prdata_c = pr_rdata_i[k*XLEN +: XLEN];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush takes priority over any same-cycle bus event
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          if (fault_c)         state_d = S_RESP;
          else if (is_cache_c) state_d = S_CREQ;
          else                 state_d = S_PWAIT;
        end
      end
      S_CREQ:  if (flush_i) state_d = S_IDLE;  else if (dc_req_ready_i) state_d = S_CWAIT;
      S_CWAIT: if (flush_i) state_d = S_DRAIN; else if (dc_rsp_valid_i) state_d = S_RESP;
      S_PWAIT: if (flush_i) state_d = S_IDLE;  else if (timeout_c || ack_hit_c) state_d = S_RESP;
      S_DRAIN: if (dc_rsp_valid_i) state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, timeout counter and result registers
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    rw_d    = rw_q;
    sel_d   = sel_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cause_d = cause_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          sign_d  = req_sign_i;
          rw_d    = req_rw_i;
          sel_d   = sel_c;
          be_d    = be_c;
          wdata_d = wdata_c;
          if (fault_c) begin
            rdata_d = '0;
            fault_d = 1'b1;
            cause_d = fcause_c;
          end
        end
      end
      S_CWAIT: begin
        if (!flush_i && dc_rsp_valid_i) begin
          rdata_d = rw_q ? '0 : load_ext(dc_rsp_data_i, addr_q[1:0], size_q, sign_q);
          fault_d = 1'b0;
          cause_d = 2'b00;
        end
      end
      S_PWAIT: begin
        if (!flush_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_c) begin
            rdata_d = '0;
            fault_d = 1'b1;
            cause_d = 2'b10;
          end else if (ack_hit_c) begin
            rdata_d = rw_q ? '0 : load_ext(prdata_c, addr_q[1:0], size_q, sign_q);
            fault_d = 1'b0;
            cause_d = 2'b00;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      rw_q    <= 1'b0;
      sel_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cause_q <= '0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rw_q    <= rw_d;
      sel_q   <= sel_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  // State-decoded handshake outputs; strobe drops once the timeout is reached
  always_comb begin
    stall_o        = 1'b0;
    done_o         = 1'b0;
    dc_req_valid_o = 1'b0;
    pr_stb_o       = '0;
    case (state_q)
      S_IDLE, S_DRAIN: stall_o = req_valid_i;
      S_CREQ: begin
        stall_o        = 1'b1;
        dc_req_valid_o = 1'b1;
      end
      S_CWAIT: stall_o = 1'b1;
      S_PWAIT: begin
        stall_o = 1'b1;
        if (!timeout_c) pr_stb_o = sel_q;
      end
      S_RESP:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign rdata_o        = rdata_q;
  assign fault_o        = fault_q;
  assign fault_cause_o  = cause_q;
  assign dc_req_addr_o  = {addr_q[XLEN-1:2], 2'b00};
  assign dc_req_rw_o    = rw_q;
  assign dc_req_be_o    = be_q;
  assign dc_req_wdata_o = wdata_q;
  assign pr_addr_o      = addr_q[PERIPH_SPAN-1:0];
  assign pr_we_o        = rw_q;
  assign pr_be_o        = be_q;
  assign pr_wdata_o     = wdata_q;

endmodule
